// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with start/valid framing.
// Ports: clk, rst (sync, active-low), start, sin, sin_vld in; busy, done, out[DW-1:0] out.
module sipo_deserializer #(
    parameter int DW        = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sin,
    input  logic          sin_vld,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] out
);

    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [DW-1:0] shreg;
    logic [DW-1:0] shreg_nxt;
    logic [DW-1:0] out_q;
    logic [DW-1:0] out_nxt;
    logic [DW-1:0] shifted;

    // Bit order decides which end the serial bit enters.
    if (MSB_FIRST) begin : g_msb
        assign shifted = {shreg[DW-2:0], sin};
    end else begin : g_lsb
        assign shifted = {sin, shreg[DW-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            out_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            out_q <= out_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        out_nxt   = out_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (sin_vld) begin
                    shreg_nxt = shifted;
                    if (cnt == CNT_LAST) begin
                        // Completed word goes straight to out, same edge.
                        out_nxt   = shifted;
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign out  = out_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: DW=16 MSB-first and DW=8 LSB-first.
// Each scenario task drives vectors and compares against hand-computed values.
module tb_sipo_deserializer;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic        sin_a;
    logic        vld_a;
    logic        busy_a;
    logic        done_a;
    logic [15:0] out_a;
    logic        start_b;
    logic        sin_b;
    logic        vld_b;
    logic        busy_b;
    logic        done_b;
    logic [7:0]  out_b;

    int n_cmp;
    int n_err;

    sipo_deserializer #(.DW(16), .MSB_FIRST(1'b1)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .start   (start_a),
        .sin     (sin_a),
        .sin_vld (vld_a),
        .busy    (busy_a),
        .done    (done_a),
        .out     (out_a)
    );

    sipo_deserializer #(.DW(8), .MSB_FIRST(1'b0)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start_b),
        .sin     (sin_b),
        .sin_vld (vld_b),
        .busy    (busy_b),
        .done    (done_b),
        .out     (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 16-bit MSB-first frame. gaps[k] inserts two idle cycles after
    // the (k+1)-th bit; start is re-pulsed on bit st_at and in DONE if st_done.
    task automatic run_a(input logic [15:0] w, input logic [15:0] gaps,
                         input int st_at, input bit st_done,
                         output int lat, output int ndone, output int nbusy_bad);
        lat = 0;
        ndone = 0;
        nbusy_bad = 0;
        start_a = 1'b1;
        vld_a = 1'b0;
        tick();
        lat++;
        start_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sin_a = w[15-i];
            vld_a = 1'b1;
            start_a = (i == st_at);
            if (busy_a !== 1'b1) nbusy_bad++;
            tick();
            lat++;
            start_a = 1'b0;
            vld_a = 1'b0;
            if (i < 15 && done_a === 1'b1) ndone++;
            if (i < 15 && gaps[i]) begin
                for (int g = 0; g < 2; g++) begin
                    if (busy_a !== 1'b1) nbusy_bad++;
                    tick();
                    lat++;
                    if (done_a === 1'b1) ndone++;
                end
            end
        end
        if (done_a === 1'b1) ndone++;
        if (busy_a !== 1'b0) nbusy_bad++;
        start_a = st_done;
        vld_a = 1'b1;
        tick();
        start_a = 1'b0;
        vld_a = 1'b0;
        if (done_a === 1'b1) ndone++;
        if (busy_a !== 1'b0) nbusy_bad++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_a = 1'b1;
        vld_a = 1'b1;
        sin_a = 1'b1;
        start_b = 1'b1;
        vld_b = 1'b1;
        sin_b = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (out_a !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_out_a: got %h want 0000", out_a);
        end
        n_cmp++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags_a: got done=%b busy=%b want 0 0", done_a, busy_a);
        end
        n_cmp++;
        if (out_b !== 8'h00 || done_b !== 1'b0 || busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: got out=%h done=%b busy=%b want 00 0 0",
                     out_b, done_b, busy_b);
        end
        rst = 1'b1;
        start_a = 1'b0;
        vld_a = 1'b0;
        sin_a = 1'b0;
        start_b = 1'b0;
        vld_b = 1'b0;
        sin_b = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_busy: got a=%b b=%b want 0 0", busy_a, busy_b);
        end
    endtask

    task automatic test_msb_frame();
        int lat, nd, nb;
        run_a(16'hA5C3, 16'h0000, -1, 1'b0, lat, nd, nb);
        n_cmp++;
        if (lat !== 17) begin
            n_err++;
            $display("FAIL msb_latency: got %0d want 17", lat);
        end
        n_cmp++;
        if (nd !== 1) begin
            n_err++;
            $display("FAIL msb_done_count: got %0d want 1", nd);
        end
        n_cmp++;
        if (nb !== 0) begin
            n_err++;
            $display("FAIL msb_busy: got %0d bad samples want 0", nb);
        end
        n_cmp++;
        if (out_a !== 16'hA5C3) begin
            n_err++;
            $display("FAIL msb_out: got %h want a5c3", out_a);
        end
        tick();
        tick();
        n_cmp++;
        if (out_a !== 16'hA5C3 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL msb_hold: got out=%h done=%b want a5c3 0", out_a, done_a);
        end
    endtask

    task automatic test_valid_gaps();
        int lat, nd, nb;
        logic [15:0] gaps;
        gaps = 16'h0000;
        gaps[2] = 1'b1;
        gaps[7] = 1'b1;
        gaps[14] = 1'b1;
        run_a(16'hA5C3, gaps, -1, 1'b0, lat, nd, nb);
        n_cmp++;
        if (lat !== 23) begin
            n_err++;
            $display("FAIL gap_latency: got %0d want 23", lat);
        end
        n_cmp++;
        if (nd !== 1 || nb !== 0) begin
            n_err++;
            $display("FAIL gap_flags: got done_cnt=%0d busy_bad=%0d want 1 0", nd, nb);
        end
        n_cmp++;
        if (out_a !== 16'hA5C3) begin
            n_err++;
            $display("FAIL gap_out: got %h want a5c3", out_a);
        end
    endtask

    task automatic test_start_ignored();
        int lat, nd, nb;
        run_a(16'h1234, 16'h0000, 5, 1'b1, lat, nd, nb);
        n_cmp++;
        if (nd !== 1 || lat !== 17) begin
            n_err++;
            $display("FAIL ign_done: got done_cnt=%0d lat=%0d want 1 17", nd, lat);
        end
        n_cmp++;
        if (out_a !== 16'h1234) begin
            n_err++;
            $display("FAIL ign_out: got %h want 1234", out_a);
        end
        tick();
        n_cmp++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || nb !== 0) begin
            n_err++;
            $display("FAIL ign_idle: got busy=%b done=%b busy_bad=%0d want 0 0 0",
                     busy_a, done_a, nb);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat, nd, nb;
        int seen;
        seen = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sin_a = 1'b1;
            vld_a = 1'b1;
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++;
        if (out_a !== 16'h0000 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_state: got out=%h busy=%b done=%b want 0000 0 0",
                     out_a, busy_a, done_a);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_a === 1'b1 || busy_a === 1'b1) seen++;
        end
        vld_a = 1'b0;
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL midrst_quiet: got %0d active samples want 0", seen);
        end
        run_a(16'h00F0, 16'h0000, -1, 1'b0, lat, nd, nb);
        n_cmp++;
        if (out_a !== 16'h00F0 || nd !== 1) begin
            n_err++;
            $display("FAIL midrst_next: got out=%h done_cnt=%0d want 00f0 1", out_a, nd);
        end
    endtask

    // 8-bit LSB-first frame; w[i] is the i-th bit sent.
    task automatic run_b(input logic [7:0] w, output int ndone);
        ndone = 0;
        start_b = 1'b1;
        vld_b = 1'b0;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sin_b = w[i];
            vld_b = 1'b1;
            tick();
            vld_b = 1'b0;
            if (done_b === 1'b1) ndone++;
        end
    endtask

    task automatic test_back_to_back();
        int nd;
        run_b(8'h01, nd);
        n_cmp++;
        if (out_b !== 8'h01 || nd !== 1) begin
            n_err++;
            $display("FAIL b2b_first: got out=%h done_cnt=%0d want 01 1", out_b, nd);
        end
        tick();
        n_cmp++;
        if (done_b !== 1'b0 || busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done_b, busy_b);
        end
        run_b(8'h80, nd);
        n_cmp++;
        if (out_b !== 8'h80 || nd !== 1) begin
            n_err++;
            $display("FAIL b2b_second: got out=%h done_cnt=%0d want 80 1", out_b, nd);
        end
        tick();
        n_cmp++;
        if (done_b !== 1'b0 || out_b !== 8'h80) begin
            n_err++;
            $display("FAIL b2b_hold: got done=%b out=%h want 0 80", done_b, out_b);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        start_a = 1'b0;
        sin_a = 1'b0;
        vld_a = 1'b0;
        start_b = 1'b0;
        sin_b = 1'b0;
        vld_b = 1'b0;
        test_reset();
        test_msb_frame();
        test_valid_gaps();
        test_start_ignored();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
